// File: rtl/aurora_link_pkg.sv
// aurora_link_pkg: shared state encoding, default cycle constants and timer sizing for the Aurora link watchdog.
package aurora_link_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PULSE,
        ST_WAIT_UP,
        ST_LINK_UP,
        ST_DEBOUNCE,
        ST_GIVE_UP
    } state_t;

    localparam int DEF_RESET_HOLD_CYCLES    = 16;
    localparam int DEF_UP_TIMEOUT_CYCLES    = 300_000_000;
    localparam int DEF_DOWN_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_MAX_RETRIES          = 8;
    localparam int DEF_CNT_W                = 16;

    // One timer serves every timed state, so it must hold the largest terminal count.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/aurora_sync_2ff.sv
// aurora_sync_2ff: W-bit two-flop synchronizer with asynchronous active-high reset.
module aurora_sync_2ff #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops resolve metastability before the value is used.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/aurora_link_watchdog.sv
// aurora_link_watchdog: Aurora sw_reset supervisor with link debounce, retry limiting and statistics; AURORA_LINK_WATCHDOG_SOFT_ERR_EN adds soft_err counting.
module aurora_link_watchdog
    import aurora_link_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES    = DEF_RESET_HOLD_CYCLES,
    parameter int UP_TIMEOUT_CYCLES    = DEF_UP_TIMEOUT_CYCLES,
    parameter int DOWN_DEBOUNCE_CYCLES = DEF_DOWN_DEBOUNCE_CYCLES,
    parameter int MAX_RETRIES          = DEF_MAX_RETRIES,
    parameter int CNT_W                = DEF_CNT_W
) (
    input  logic             init_clk,
    input  logic             init_rst,
    input  logic             channel_up,
    input  logic             hard_err,
    input  logic             auto_recover_en,
    input  logic             reset_req,
    input  logic             clear_stats,
    output logic             sw_reset,
    output logic             link_up,
    output logic             gave_up,
    output logic [CNT_W-1:0] recovery_count,
    output logic [CNT_W-1:0] link_drop_count
`ifdef AURORA_LINK_WATCHDOG_SOFT_ERR_EN
    ,
    input  logic             soft_err,
    output logic [CNT_W-1:0] soft_err_count
`endif
);

    localparam int TW = timer_width(RESET_HOLD_CYCLES, UP_TIMEOUT_CYCLES, DOWN_DEBOUNCE_CYCLES);
    localparam int FW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

`ifdef AURORA_LINK_WATCHDOG_SOFT_ERR_EN
    localparam int SW = 3;
    logic [SW-1:0] w_sync_in;
    assign w_sync_in = {soft_err, hard_err, channel_up};
`else
    localparam int SW = 2;
    logic [SW-1:0] w_sync_in;
    assign w_sync_in = {hard_err, channel_up};
`endif

    logic [SW-1:0]    w_sync_q;
    logic             w_ch_up_s;
    logic             w_herr_s;
    state_t           r_state;
    logic [TW-1:0]    r_timer;
    logic [FW-1:0]    r_fail_cnt;
    logic             r_sw_reset;
    logic             r_link_up;
    logic             r_gave_up;
    logic [CNT_W-1:0] r_rec_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    aurora_sync_2ff #(.W(SW)) u_sync (
        .i_clk (init_clk),
        .i_rst (init_rst),
        .i_d   (w_sync_in),
        .o_q   (w_sync_q)
    );

    assign w_ch_up_s = w_sync_q[0];
    assign w_herr_s  = w_sync_q[1];

    // Supervisor FSM: outputs are registered alongside the next state; clear_stats is applied last so it beats any increment.
    always_ff @(posedge init_clk or posedge init_rst) begin
        if (init_rst) begin
            r_state    <= ST_RESET_PULSE;
            r_timer    <= '0;
            r_fail_cnt <= '0;
            r_sw_reset <= 1'b1;
            r_link_up  <= 1'b0;
            r_gave_up  <= 1'b0;
            r_rec_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (reset_req) begin
                r_state    <= ST_RESET_PULSE;
                r_timer    <= '0;
                r_fail_cnt <= '0;
                r_sw_reset <= 1'b1;
                r_link_up  <= 1'b0;
                r_gave_up  <= 1'b0;
            end else begin
                case (r_state)
                    ST_RESET_PULSE: begin
                        if (r_timer == TW'(RESET_HOLD_CYCLES - 1)) begin
                            r_state    <= ST_WAIT_UP;
                            r_timer    <= '0;
                            r_sw_reset <= 1'b0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_WAIT_UP: begin
                        if (auto_recover_en && r_timer == TW'(UP_TIMEOUT_CYCLES - 1)) begin
                            r_timer    <= '0;
                            r_sw_reset <= 1'b1;
                            if (~&r_fail_cnt)
                                r_fail_cnt <= r_fail_cnt + 1'b1;
                            if (MAX_RETRIES != 0 && int'(r_fail_cnt) + 1 >= MAX_RETRIES) begin
                                r_state   <= ST_GIVE_UP;
                                r_gave_up <= 1'b1;
                            end else begin
                                r_state <= ST_RESET_PULSE;
                                if (~&r_rec_cnt)
                                    r_rec_cnt <= r_rec_cnt + 1'b1;
                            end
                        end else if (w_ch_up_s) begin
                            r_state    <= ST_LINK_UP;
                            r_timer    <= '0;
                            r_fail_cnt <= '0;
                            r_link_up  <= 1'b1;
                        end else if (r_timer != TW'(UP_TIMEOUT_CYCLES - 1)) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_LINK_UP, ST_DEBOUNCE: begin
                        if (w_herr_s || (r_state == ST_DEBOUNCE && r_timer == TW'(DOWN_DEBOUNCE_CYCLES - 1))) begin
                            r_timer   <= '0;
                            r_link_up <= 1'b0;
                            if (~&r_drop_cnt)
                                r_drop_cnt <= r_drop_cnt + 1'b1;
                            if (auto_recover_en) begin
                                r_state    <= ST_RESET_PULSE;
                                r_sw_reset <= 1'b1;
                                if (~&r_rec_cnt)
                                    r_rec_cnt <= r_rec_cnt + 1'b1;
                            end else begin
                                r_state <= ST_WAIT_UP;
                            end
                        end else if (r_state == ST_LINK_UP) begin
                            if (!w_ch_up_s) begin
                                r_state <= ST_DEBOUNCE;
                                r_timer <= '0;
                            end
                        end else if (w_ch_up_s) begin
                            r_state <= ST_LINK_UP;
                            r_timer <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    ST_GIVE_UP: begin
                        r_sw_reset <= 1'b1;
                        r_gave_up  <= 1'b1;
                    end
                    default: begin
                        r_state    <= ST_RESET_PULSE;
                        r_timer    <= '0;
                        r_sw_reset <= 1'b1;
                        r_link_up  <= 1'b0;
                        r_gave_up  <= 1'b0;
                    end
                endcase
            end
            if (clear_stats) begin
                r_rec_cnt  <= '0;
                r_drop_cnt <= '0;
            end
        end
    end

    assign sw_reset        = r_sw_reset;
    assign link_up         = r_link_up;
    assign gave_up         = r_gave_up;
    assign recovery_count  = r_rec_cnt;
    assign link_drop_count = r_drop_cnt;

`ifdef AURORA_LINK_WATCHDOG_SOFT_ERR_EN
    logic             r_serr_d;
    logic [CNT_W-1:0] r_serr_cnt;

    // Count rising edges of the synchronised soft_err only while the link is fully up.
    always_ff @(posedge init_clk or posedge init_rst) begin
        if (init_rst) begin
            r_serr_d   <= 1'b0;
            r_serr_cnt <= '0;
        end else begin
            r_serr_d <= w_sync_q[2];
            if (clear_stats)
                r_serr_cnt <= '0;
            else if (w_sync_q[2] && !r_serr_d && r_state == ST_LINK_UP && ~&r_serr_cnt)
                r_serr_cnt <= r_serr_cnt + 1'b1;
        end
    end

    assign soft_err_count = r_serr_cnt;
`endif

endmodule

// File: tb/tb_aurora_link_watchdog.sv
// tb_aurora_link_watchdog: directed self-checking bench for aurora_link_watchdog with short cycle parameters.
module tb_aurora_link_watchdog;

    localparam int CW = 3;

    logic          init_clk = 1'b0;
    logic          init_rst;
    logic          channel_up;
    logic          hard_err;
    logic          auto_recover_en;
    logic          reset_req;
    logic          clear_stats;
    logic          sw_reset;
    logic          link_up;
    logic          gave_up;
    logic [CW-1:0] recovery_count;
    logic [CW-1:0] link_drop_count;
`ifdef AURORA_LINK_WATCHDOG_SOFT_ERR_EN
    logic          soft_err = 1'b0;
    logic [CW-1:0] soft_err_count;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n;
    logic seen;

    aurora_link_watchdog #(
        .RESET_HOLD_CYCLES    (4),
        .UP_TIMEOUT_CYCLES    (50),
        .DOWN_DEBOUNCE_CYCLES (5),
        .MAX_RETRIES          (2),
        .CNT_W                (CW)
    ) dut (
        .init_clk        (init_clk),
        .init_rst        (init_rst),
        .channel_up      (channel_up),
        .hard_err        (hard_err),
        .auto_recover_en (auto_recover_en),
        .reset_req       (reset_req),
        .clear_stats     (clear_stats),
        .sw_reset        (sw_reset),
        .link_up         (link_up),
        .gave_up         (gave_up),
        .recovery_count  (recovery_count),
        .link_drop_count (link_drop_count)
`ifdef AURORA_LINK_WATCHDOG_SOFT_ERR_EN
        ,
        .soft_err        (soft_err),
        .soft_err_count  (soft_err_count)
`endif
    );

    always #5 init_clk = ~init_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge init_clk);
        #1;
    endtask

    task automatic wait_link(input string tag);
        int i;
        i = 0;
        while (!link_up && i < 40) begin
            step(1);
            i++;
        end
        chk(tag, link_up, 1);
    endtask

    task automatic wait_sw(input string tag);
        int i;
        i = 0;
        while (!sw_reset && i < 40) begin
            step(1);
            i++;
        end
        chk(tag, sw_reset, 1);
    endtask

    task automatic pulse_len(output int len);
        len = 0;
        while (sw_reset && len < 40) begin
            len++;
            step(1);
        end
    endtask

    task automatic do_reset();
        init_rst = 1'b1;
        step(2);
        init_rst = 1'b0;
    endtask

    initial begin
        init_rst = 1'b1;
        channel_up = 1'b0;
        hard_err = 1'b0;
        auto_recover_en = 1'b1;
        reset_req = 1'b0;
        clear_stats = 1'b0;
        step(3);
        chk("rst_sw", sw_reset, 1);
        chk("rst_link", link_up, 0);
        chk("rst_gave", gave_up, 0);
        chk("rst_rec", recovery_count, 0);
        chk("rst_drop", link_drop_count, 0);

        init_rst = 1'b0;
        pulse_len(n);
        chk("boot_pulse_len", n, 4);
        step(6);
        channel_up = 1'b1;
        step(2);
        chk("up_latency_early", link_up, 0);
        step(1);
        chk("up_latency", link_up, 1);

        channel_up = 1'b0;
        step(3);
        channel_up = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (sw_reset || !link_up) seen = 1'b1;
        end
        chk("flap_quiet", seen, 0);
        chk("flap_drop", link_drop_count, 0);

        channel_up = 1'b0;
        wait_sw("drop_pulse_seen");
        chk("drop_cnt", link_drop_count, 1);
        chk("drop_rec", recovery_count, 1);
        chk("drop_link", link_up, 0);
        pulse_len(n);
        chk("drop_pulse_len", n, 4);
        channel_up = 1'b1;
        wait_link("relink1");

        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        chk("clear_rec", recovery_count, 0);
        chk("clear_drop", link_drop_count, 0);

        hard_err = 1'b1;
        step(1);
        hard_err = 1'b0;
        step(1);
        chk("herr_pre_sw", sw_reset, 0);
        step(1);
        chk("herr_sw", sw_reset, 1);
        chk("herr_drop", link_drop_count, 1);
        chk("herr_link", link_up, 0);
        wait_link("relink2");

        hard_err = 1'b1;
        step(1);
        hard_err = 1'b0;
        step(1);
        clear_stats = 1'b1;
        step(1);
        clear_stats = 1'b0;
        chk("clr_vs_inc_sw", sw_reset, 1);
        chk("clr_vs_inc_drop", link_drop_count, 0);
        wait_link("relink3");

        channel_up = 1'b0;
        do_reset();
        step(4);
        chk("to_pulse_end", sw_reset, 0);
        n = 4;
        while (!sw_reset && n < 100) begin
            step(1);
            n++;
        end
        chk("to_cycles", n, 54);
        chk("to_rec", recovery_count, 1);
        chk("to_gave0", gave_up, 0);
        n = 0;
        while (!gave_up && n < 100) begin
            step(1);
            n++;
        end
        chk("gave_up", gave_up, 1);
        chk("gave_sw", sw_reset, 1);
        chk("gave_rec", recovery_count, 1);
        step(20);
        chk("park_sw", sw_reset, 1);
        chk("park_gave", gave_up, 1);
        reset_req = 1'b1;
        step(1);
        reset_req = 1'b0;
        chk("req_gave", gave_up, 0);
        chk("req_rec", recovery_count, 1);
        chk("req_sw", sw_reset, 1);

        auto_recover_en = 1'b0;
        do_reset();
        step(5);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (sw_reset) seen = 1'b1;
        end
        chk("noauto_sw", seen, 0);
        chk("noauto_rec", recovery_count, 0);
        chk("noauto_drop", link_drop_count, 0);
        chk("noauto_gave", gave_up, 0);

        auto_recover_en = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            channel_up = 1'b1;
            wait_link("sat_link");
            channel_up = 1'b0;
            wait_sw("sat_sw");
        end
        chk("sat_rec", recovery_count, 7);
        chk("sat_drop", link_drop_count, 7);

        channel_up = 1'b1;
        wait_link("db_link");
        channel_up = 1'b0;
        step(4);
        chk("db_still_up", link_up, 1);
        #2;
        init_rst = 1'b1;
        #1;
        chk("async_sw", sw_reset, 1);
        chk("async_link", link_up, 0);
        chk("async_gave", gave_up, 0);
        chk("async_rec", recovery_count, 0);
        chk("async_drop", link_drop_count, 0);
        step(2);
        init_rst = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aurora_link_watchdog.md
Name: aurora_link_watchdog

Overview:
- Link supervisor that generates the sw_reset input of the Aurora core reset sequencer, in the init_clk domain.
- Holds the link in reset out of power-up and releases it.
- Monitors channel_up and hard_err from the Aurora core.
- On link loss, a hard error, or a bring-up timeout, re-issues a sw_reset pulse, with retry limiting and statistics counters for the RFNoC register space.

Parameters:
- RESET_HOLD_CYCLES, 16, init_clk cycles sw_reset is held high per pulse (min 2).
- UP_TIMEOUT_CYCLES, 300_000_000, cycles to wait for channel_up after releasing sw_reset. Must exceed the sequencer's pma_init hold (3 s at 100 MHz).
- DOWN_DEBOUNCE_CYCLES, 1000, cycles channel_up must stay low before a drop is declared.
- MAX_RETRIES, 8, consecutive failed recoveries before giving up; 0 = unlimited.
- CNT_W, 16, width of statistics counters.

Ports:
- init_clk  in  1  free-running clock, same clock as the reset sequencer.
- init_rst  in  1  asynchronous, active-high reset.
- channel_up  in  1  Aurora channel_up, asynchronous to init_clk (user_clk domain).
- hard_err  in  1  Aurora hard_err level, asynchronous.
- auto_recover_en  in  1  enables automatic recovery; synchronous, quasi-static.
- reset_req  in  1  single-cycle manual link-reset request.
- clear_stats  in  1  single-cycle pulse; clears all counters.
- sw_reset  out  1  drives the reset sequencer sw_reset input.
- link_up  out  1  debounced link status.
- gave_up  out  1  retry limit reached; the block is parked.
- recovery_count  out  CNT_W  automatic recoveries issued; saturating.
- link_drop_count  out  CNT_W  declared link drops, including hard_err; saturating.

Behaviour:
- Synchronisation: channel_up and hard_err each pass through a 2-FF synchronizer (reset to 0). The FSM uses only the synchronised versions (ch_up_s, herr_s).
- Reset values: sw_reset=1, link_up=0, gave_up=0, counters=0, fail_cnt=0, state=ST_RESET_PULSE, timer=0.
- Single timer: cleared on every state entry, incremented each cycle while in a timed state.
- ST_RESET_PULSE:
  - sw_reset=1.
  - Leave when timer==RESET_HOLD_CYCLES-1, go to ST_WAIT_UP.
  - sw_reset is high exactly RESET_HOLD_CYCLES cycles after reset release.
- ST_WAIT_UP: sw_reset=0.
  - ch_up_s=1: go to ST_LINK_UP, fail_cnt cleared.
  - timer==UP_TIMEOUT_CYCLES-1 with auto_recover_en=1: fail_cnt++. If MAX_RETRIES!=0 and fail_cnt reaches MAX_RETRIES, go to ST_GIVE_UP; otherwise recovery_count++ and go to ST_RESET_PULSE.
  - auto_recover_en=0: timer saturates and the block waits indefinitely.
- ST_LINK_UP: link_up=1.
  - herr_s=1: link_drop_count++; go to ST_RESET_PULSE if auto_recover_en, else ST_WAIT_UP.
  - ch_up_s=0: go to ST_DEBOUNCE.
- ST_DEBOUNCE: link_up stays 1.
  - ch_up_s returns to 1: back to ST_LINK_UP, no count.
  - timer==DOWN_DEBOUNCE_CYCLES-1: link_drop_count++; go to ST_RESET_PULSE (recovery_count++) if auto_recover_en, else ST_WAIT_UP.
- ST_GIVE_UP: sw_reset=1, gave_up=1. Exit only via reset_req.
- reset_req priority:
  - Highest priority, accepted in any state including ST_RESET_PULSE, where it restarts the timer.
  - Next cycle: ST_RESET_PULSE, fail_cnt=0, gave_up=0. recovery_count is not incremented.
  - Priority order: reset_req > herr_s > timeout/debounce > ch_up_s.
- Counters saturate at all-ones.
- clear_stats zeroes both counters. Coinciding with an increment, the clear wins.
- Outputs are registered; sw_reset changes the cycle after the state decision.
- Reset asserted mid-operation returns every state and output immediately (asynchronously) to the reset values.

Optional Feature:
- Macro: AURORA_LINK_WATCHDOG_SOFT_ERR_EN.
- When defined:
  - Extra input soft_err (async, 2-FF synchronised) and output soft_err_count [CNT_W-1:0].
  - Each rising edge of the synchronised soft_err in ST_LINK_UP increments soft_err_count, saturating, cleared by clear_stats.
  - Rising edges in other states are ignored.
- When undefined: the port, the counter and the synchronizer are absent.

Decomposition:
- Package aurora_link_pkg holds:
  - state_t enum: ST_RESET_PULSE, ST_WAIT_UP, ST_LINK_UP, ST_DEBOUNCE, ST_GIVE_UP.
  - Timer width function: $clog2 of the max of the cycle parameters plus 1.
  - The default cycle constants.
- One sub-module, aurora_sync_2ff: parameterised-width 2-FF synchronizer with asynchronous reset, instantiated once for the status inputs.

Test Plan (use RESET_HOLD_CYCLES=4, UP_TIMEOUT_CYCLES=50, DOWN_DEBOUNCE_CYCLES=5, MAX_RETRIES=2):
- Reset release: sw_reset high for exactly 4 cycles, then 0. channel_up asserted 10 cycles later, so link_up=1 after 2-FF + 1 cycles.
- Link flap: drop channel_up for 3 cycles, so no drop counted and sw_reset stays 0. Drop it for 6+ cycles: link_drop_count=1, recovery_count=1, 4-cycle sw_reset pulse.
- hard_err pulse of 1 cycle while link_up=1: link_drop_count=1 and an immediate sw_reset pulse, with no debounce wait.
- channel_up never asserted with auto_recover_en=1:
  - One timeout: sw_reset pulse, recovery_count=1.
  - Second timeout: gave_up=1, sw_reset=1 held.
  - reset_req: gave_up=0, recovery_count unchanged at 1.
- auto_recover_en=0 with channel_up never asserted: sw_reset remains 0 for 200 cycles and counters stay 0.
- Saturation/clear:
  - Force recovery_count to all-ones via repeated drops: no wrap.
  - clear_stats on the same cycle as a drop increment: counter reads 0.
  - init_rst mid-ST_DEBOUNCE: all outputs return to reset values immediately.
